// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencer: command opcodes, FSM states and a small helper.
package cnt_seq_ctrl_pkg;

  localparam logic [1:0] OP_CLR   = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_RUN   = 2'b10;
  localparam logic [1:0] OP_PAUSE = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StLoad,
    StRun,
    StPause
  } state_e;

  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// Command/status port of the counter sequencer; master is the host, slave is the sequencer.
interface cnt_seq_ctrl_if #(
  parameter int unsigned N = 3
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [N-1:0] cmd_data;
  logic         cmd_up;
  logic         abort;
  logic         busy;
  logic         done;
  logic         done_wrap;
  logic         aborted;
  logic [N-1:0] q;

  modport master (
    output cmd_valid, cmd_op, cmd_data, cmd_up, abort,
    input  cmd_ready, busy, done, done_wrap, aborted, q
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data, cmd_up, abort,
    output cmd_ready, busy, done, done_wrap, aborted, q
  );
endinterface

// File: rtl/bin_counter.sv
// N-bit universal binary counter: synchronous clear, parallel load, up/down count enable.
module bin_counter #(
  parameter int unsigned N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         syn_clr_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic         up_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o,
  output logic         max_tick_o,
  output logic         min_tick_o
);

  logic [N-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (syn_clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = d_i;
    end else if (en_i) begin
      q_d = up_i ? q_q + N'(1) : q_q - N'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o        = q_q;
  assign max_tick_o = (q_q == {N{1'b1}});
  assign min_tick_o = (q_q == '0);

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command sequencer driving one bin_counter: CLR, LOAD, RUN-to-target and PAUSE with abort.
// Note: rst_n is an active-high asynchronous reset despite its name.
module cnt_seq_ctrl
  import cnt_seq_ctrl_pkg::*;
#(
  parameter int unsigned N  = 3,
  parameter int unsigned HW = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  cnt_seq_ctrl_if.slave  bus_io
);

  localparam int unsigned PW = min_u(N, HW);

  state_e        state_q, state_d;
  logic [N-1:0]  data_q;
  logic          up_q;
  logic [HW-1:0] hold_q;
  logic          wrap_q;
  logic          done_q, done_wrap_q, aborted_q;

  logic          accept;
  logic          cnt_syn_clr, cnt_load, cnt_en;
  logic [N-1:0]  cnt_q;
  logic          cnt_max, cnt_min;
  logic          wrap_hit, finish_ok, abort_hit;
  logic [HW-1:0] pause_len;

  assign bus_io.cmd_ready = (state_q == StIdle) & ~bus_io.abort & ~rst_n;
  assign accept           = bus_io.cmd_valid & bus_io.cmd_ready;

  always_comb begin
    pause_len         = '0;
    pause_len[PW-1:0] = bus_io.cmd_data[PW-1:0];
  end

  always_comb begin
    state_d     = state_q;
    cnt_syn_clr = 1'b0;
    cnt_load    = 1'b0;
    cnt_en      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (bus_io.cmd_op)
            OP_CLR:   state_d = StClr;
            OP_LOAD:  state_d = StLoad;
            OP_RUN:   state_d = StRun;
            OP_PAUSE: state_d = StPause;
            default:  state_d = StIdle;
          endcase
        end
      end
      StClr: begin
        cnt_syn_clr = ~bus_io.abort;
        state_d     = StIdle;
      end
      StLoad: begin
        cnt_load = ~bus_io.abort;
        state_d  = StIdle;
      end
      StRun: begin
        cnt_en = (cnt_q != data_q) & ~bus_io.abort;
        if ((cnt_q == data_q) || bus_io.abort) begin
          state_d = StIdle;
        end
      end
      StPause: begin
        if ((hold_q == '0) || bus_io.abort) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign wrap_hit  = cnt_en & ((up_q & cnt_max) | (~up_q & cnt_min));
  assign abort_hit = (state_q != StIdle) & bus_io.abort;
  assign finish_ok = (state_q != StIdle) & ~bus_io.abort & (state_d == StIdle);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= StIdle;
      data_q      <= '0;
      up_q        <= 1'b0;
      hold_q      <= '0;
      wrap_q      <= 1'b0;
      done_q      <= 1'b0;
      done_wrap_q <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q <= bus_io.cmd_data;
        up_q   <= bus_io.cmd_up;
        hold_q <= pause_len;
      end else if ((state_q == StPause) && (hold_q != '0)) begin
        hold_q <= hold_q - HW'(1);
      end
      wrap_q      <= accept ? 1'b0 : (wrap_q | wrap_hit);
      done_q      <= finish_ok;
      // A RUN ends with en=0, so any wrap has already landed in wrap_q.
      done_wrap_q <= finish_ok & (state_q == StRun) & wrap_q;
      aborted_q   <= abort_hit;
    end
  end

  bin_counter #(
    .N (N)
  ) u_cnt (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .syn_clr_i  (cnt_syn_clr),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .up_i       (up_q),
    .d_i        (data_q),
    .q_o        (cnt_q),
    .max_tick_o (cnt_max),
    .min_tick_o (cnt_min)
  );

  assign bus_io.busy      = (state_q != StIdle);
  assign bus_io.done      = done_q;
  assign bus_io.done_wrap = done_wrap_q;
  assign bus_io.aborted   = aborted_q;
  assign bus_io.q         = cnt_q;

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Bench for cnt_seq_ctrl: per-cycle schedule model plus directed latency/value checks.
module tb_cnt_seq_ctrl;

  localparam int unsigned N = 3;
  localparam logic [1:0] C_CLR = 2'b00, C_LOAD = 2'b01, C_RUN = 2'b10, C_PAUSE = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  cnt_seq_ctrl_if #(.N(N)) bus ();

  cnt_seq_ctrl #(
    .N  (N),
    .HW (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: on accept, the whole command is reduced to a busy length and a step count.
  int           m_left = 0;
  int           m_steps = 0;
  logic [1:0]   m_kind = 2'b00;
  logic [N-1:0] m_q = '0, m_data = '0, m_dist;
  logic         m_up = 1'b0, m_wrap = 1'b0;
  logic         m_done = 1'b0, m_dw = 1'b0, m_ab = 1'b0;

  initial begin
    logic nd, ndw, nab, exp_ready;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        m_q = '0; m_left = 0; m_done = 1'b0; m_dw = 1'b0; m_ab = 1'b0;
      end
      exp_ready = (m_left == 0) && !bus.abort && !rst_n;
      chk("cyc_q", bus.q, m_q);
      chk("cyc_busy", bus.busy, (m_left > 0) ? 1 : 0);
      chk("cyc_done", bus.done, m_done);
      chk("cyc_done_wrap", bus.done_wrap, m_dw);
      chk("cyc_aborted", bus.aborted, m_ab);
      chk("cyc_ready", bus.cmd_ready, exp_ready);
      nd = 1'b0; ndw = 1'b0; nab = 1'b0;
      if (rst_n) begin
        m_left = 0;
      end else if (m_left > 0) begin
        if (bus.abort) begin
          m_left = 0;
          nab = 1'b1;
        end else begin
          case (m_kind)
            C_CLR:  m_q = '0;
            C_LOAD: m_q = m_data;
            C_RUN:  if (m_steps > 0) begin
                      m_q = m_up ? m_q + N'(1) : m_q - N'(1);
                      m_steps--;
                    end
            default: ;
          endcase
          m_left--;
          if (m_left == 0) begin
            nd  = 1'b1;
            ndw = (m_kind == C_RUN) && m_wrap;
          end
        end
      end else if (bus.cmd_valid && exp_ready) begin
        m_kind = bus.cmd_op;
        m_data = bus.cmd_data;
        m_up   = bus.cmd_up;
        case (bus.cmd_op)
          C_RUN: begin
            m_dist  = m_up ? m_data - m_q : m_q - m_data;
            m_steps = int'(m_dist);
            m_left  = m_steps + 1;
            m_wrap  = m_up ? (int'(m_q) + m_steps >= (1 << N)) : (m_steps > int'(m_q));
          end
          C_PAUSE: m_left = int'(m_data) + 1;
          default: m_left = 1;
        endcase
      end
      m_done = nd; m_dw = ndw; m_ab = nab;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [N-1:0] data, input logic up,
                       input int abort_at, output int lat, output logic dn, output logic dw,
                       output logic ab);
    int w = 0;
    while (!bus.cmd_ready && w < 20) begin
      tick();
      w++;
    end
    chk("ready_before_issue", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    bus.cmd_up    = up;
    tick();
    bus.cmd_valid = 1'b0;
    lat = 1; dn = 1'b0; dw = 1'b0; ab = 1'b0;
    while (lat < 40) begin
      if (bus.done || bus.aborted) begin
        dn = bus.done; dw = bus.done_wrap; ab = bus.aborted;
        break;
      end
      bus.abort = (lat == abort_at);
      tick();
      lat++;
    end
    bus.abort = 1'b0;
  endtask

  initial begin
    int   lat;
    logic dn, dw, ab;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_data  = '0;
    bus.cmd_up    = 1'b0;
    bus.abort     = 1'b0;
    repeat (3) tick();
    chk("rst_q", bus.q, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.cmd_ready, 0);
    rst_n = 1'b0;
    tick();
    chk("post_rst_ready", bus.cmd_ready, 1);

    // 1: LOAD 3
    issue(C_LOAD, 3'd3, 1'b0, 0, lat, dn, dw, ab);
    chk("load_lat", lat, 2); chk("load_done", dn, 1); chk("load_wrap", dw, 0);
    chk("load_q", bus.q, 3);

    // 2: q=6, RUN up to 1 wraps 7,0,1
    issue(C_LOAD, 3'd6, 1'b0, 0, lat, dn, dw, ab);
    issue(C_RUN, 3'd1, 1'b1, 0, lat, dn, dw, ab);
    chk("run_up_lat", lat, 5); chk("run_up_wrap", dw, 1); chk("run_up_q", bus.q, 1);

    // 3: q=2, RUN down to 2, no count
    issue(C_LOAD, 3'd2, 1'b0, 0, lat, dn, dw, ab);
    issue(C_RUN, 3'd2, 1'b0, 0, lat, dn, dw, ab);
    chk("run_d0_lat", lat, 2); chk("run_d0_wrap", dw, 0); chk("run_d0_q", bus.q, 2);

    // 4: PAUSE 4 with q=5, then PAUSE 0
    issue(C_LOAD, 3'd5, 1'b0, 0, lat, dn, dw, ab);
    issue(C_PAUSE, 3'd4, 1'b1, 0, lat, dn, dw, ab);
    chk("pause4_lat", lat, 6); chk("pause4_q", bus.q, 5); chk("pause4_wrap", dw, 0);
    issue(C_PAUSE, 3'd0, 1'b0, 0, lat, dn, dw, ab);
    chk("pause0_lat", lat, 2);

    // Down wrap and non-wrapping run
    issue(C_LOAD, 3'd1, 1'b0, 0, lat, dn, dw, ab);
    issue(C_RUN, 3'd6, 1'b0, 0, lat, dn, dw, ab);
    chk("run_dn_lat", lat, 5); chk("run_dn_wrap", dw, 1); chk("run_dn_q", bus.q, 6);
    issue(C_LOAD, 3'd1, 1'b0, 0, lat, dn, dw, ab);
    issue(C_RUN, 3'd4, 1'b1, 0, lat, dn, dw, ab);
    chk("run_nw_lat", lat, 5); chk("run_nw_wrap", dw, 0); chk("run_nw_q", bus.q, 4);

    // 5: CLR, then RUN up to 7 aborted at accept+3
    issue(C_CLR, 3'd5, 1'b0, 0, lat, dn, dw, ab);
    chk("clr_lat", lat, 2); chk("clr_q", bus.q, 0);
    issue(C_RUN, 3'd7, 1'b1, 3, lat, dn, dw, ab);
    chk("abort_lat", lat, 4); chk("abort_flag", ab, 1); chk("abort_done", dn, 0);
    chk("abort_q", bus.q, 2);

    // Abort during PAUSE, and abort in IDLE beats cmd_valid
    issue(C_PAUSE, 3'd6, 1'b0, 2, lat, dn, dw, ab);
    chk("pabort_lat", lat, 3); chk("pabort_flag", ab, 1); chk("pabort_q", bus.q, 2);
    bus.abort = 1'b1; bus.cmd_valid = 1'b1; bus.cmd_op = C_LOAD; bus.cmd_data = 3'd7;
    #1;
    chk("idle_abort_ready", bus.cmd_ready, 0);
    tick();
    bus.abort = 1'b0; bus.cmd_valid = 1'b0;
    chk("idle_abort_busy", bus.busy, 0); chk("idle_abort_q", bus.q, 2);

    // 6: valid held through CLR then queued LOAD 4
    while (!bus.cmd_ready) tick();
    bus.cmd_valid = 1'b1; bus.cmd_op = C_CLR; bus.cmd_data = 3'd0;
    tick();
    bus.cmd_op = C_LOAD; bus.cmd_data = 3'd4;
    tick();
    chk("q6_clr_done", bus.done, 1); chk("q6_clr_q", bus.q, 0);
    tick();
    bus.cmd_valid = 1'b0;
    chk("q6_load_busy", bus.busy, 1);
    tick();
    chk("q6_load_done", bus.done, 1); chk("q6_load_q", bus.q, 4);

    // Reset mid-RUN
    bus.cmd_valid = 1'b1; bus.cmd_op = C_RUN; bus.cmd_data = 3'd3; bus.cmd_up = 1'b1;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_q", bus.q, 6);
    rst_n = 1'b1;
    #2;
    chk("midrst_q", bus.q, 0); chk("midrst_busy", bus.busy, 0);
    tick();
    rst_n = 1'b0;
    repeat (3) tick();
    chk("after_rst_done", bus.done, 0); chk("after_rst_q", bus.q, 0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
